// File: rtl/posit_mult_pipe.sv
// Three-stage pipelined multiplier for unpacked posit operands with valid/ready handshake.
// Optional output normalisation is enabled by defining POSIT_MULT_NORM_EN.
module posit_mult_pipe #(
   parameter int FRAC_W  = 12,
   parameter int SCALE_W = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rts_i,
   output logic                      rtr_o,
   input  logic                      sow_i,
   input  logic                      eow_i,
   input  logic [FRAC_W-1:0]         fraction_i1,
   input  logic [FRAC_W-1:0]         fraction_i2,
   input  logic [SCALE_W-1:0]        scale_i1,
   input  logic [SCALE_W-1:0]        scale_i2,
   input  logic                      NaR_i1,
   input  logic                      NaR_i2,
   input  logic                      zero_i1,
   input  logic                      zero_i2,
   input  logic                      sign_i1,
   input  logic                      sign_i2,
   input  logic                      rtr_i,
   output logic                      rts_o,
   output logic                      sow_o,
   output logic                      eow_o,
   output logic [2*(FRAC_W+1)-1:0]   fraction_o,
   output logic [SCALE_W:0]          scale_o,
   output logic                      NaR_o,
   output logic                      zero_o,
   output logic                      sign_o
);

   localparam int MW = FRAC_W + 1;
   localparam int PW = 2 * MW;
   localparam int SW = SCALE_W + 1;

   logic              init_done;
   logic              adv1, adv2, adv3;

   logic              v1, sow1, eow1, nar1, zero1, sign1;
   logic [MW-1:0]     m1a, m1b;
   logic [SCALE_W-1:0] sc1a, sc1b;

   logic              v2, sow2, eow2, nar2, zero2, sign2;
   logic [PW-1:0]     p2;
   logic [SW-1:0]     s2;

   logic              v3, sow3, eow3, nar3, zero3, sign3;
   logic [PW-1:0]     frac3;
   logic [SW-1:0]     scale3;

   logic              dec_nar, dec_zero, dec_spec;
   logic [PW-1:0]     frac_n;
   logic [SW-1:0]     scale_n;

   // Input acceptance is held off until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) init_done <= 1'b0;
      else        init_done <= 1'b1;
   end

   assign adv3  = !v3 || rtr_i;
   assign adv2  = !v2 || adv3;
   assign adv1  = init_done && (!v1 || adv2);
   assign rtr_o = adv1;

   assign dec_nar  = NaR_i1 || NaR_i2;
   assign dec_zero = !dec_nar && (zero_i1 || zero_i2);
   assign dec_spec = dec_nar || dec_zero;

   // S1: capture operands, resolve specials, squash ignored fields to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         sow1  <= 1'b0;
         eow1  <= 1'b0;
         nar1  <= 1'b0;
         zero1 <= 1'b0;
         sign1 <= 1'b0;
         m1a   <= '0;
         m1b   <= '0;
         sc1a  <= '0;
         sc1b  <= '0;
      end else if (adv1) begin
         v1 <= rts_i;
         if (rts_i) begin
            sow1  <= sow_i;
            eow1  <= eow_i;
            nar1  <= dec_nar;
            zero1 <= dec_zero;
            sign1 <= !dec_spec && (sign_i1 ^ sign_i2);
            m1a   <= dec_spec ? '0 : {1'b1, fraction_i1};
            m1b   <= dec_spec ? '0 : {1'b1, fraction_i2};
            sc1a  <= dec_spec ? '0 : scale_i1;
            sc1b  <= dec_spec ? '0 : scale_i2;
         end
      end
   end

   // S2: full-width mantissa product and sign-extended scale sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         sow2  <= 1'b0;
         eow2  <= 1'b0;
         nar2  <= 1'b0;
         zero2 <= 1'b0;
         sign2 <= 1'b0;
         p2    <= '0;
         s2    <= '0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            sow2  <= sow1;
            eow2  <= eow1;
            nar2  <= nar1;
            zero2 <= zero1;
            sign2 <= sign1;
            p2    <= PW'(m1a) * PW'(m1b);
            s2    <= {sc1a[SCALE_W-1], sc1a} + {sc1b[SCALE_W-1], sc1b};
         end
      end
   end

   always_comb begin
      frac_n  = p2;
      scale_n = s2;
`ifdef POSIT_MULT_NORM_EN
      if (p2[PW-1]) begin
         frac_n  = p2;
         scale_n = s2 + SW'(1);
      end else begin
         frac_n  = p2 << 1;
         scale_n = s2;
      end
`endif
      if (nar2 || zero2) begin
         frac_n  = '0;
         scale_n = '0;
      end
   end

   // S3: result register; fields hold while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3     <= 1'b0;
         sow3   <= 1'b0;
         eow3   <= 1'b0;
         nar3   <= 1'b0;
         zero3  <= 1'b0;
         sign3  <= 1'b0;
         frac3  <= '0;
         scale3 <= '0;
      end else if (adv3) begin
         v3 <= v2;
         if (v2) begin
            sow3   <= sow2;
            eow3   <= eow2;
            nar3   <= nar2;
            zero3  <= zero2;
            sign3  <= sign2;
            frac3  <= frac_n;
            scale3 <= scale_n;
         end
      end
   end

   assign rts_o      = v3;
   assign sow_o      = v3 && sow3;
   assign eow_o      = v3 && eow3;
   assign NaR_o      = nar3;
   assign zero_o     = zero3;
   assign sign_o     = sign3;
   assign fraction_o = frac3;
   assign scale_o    = scale3;

endmodule
